// File: rtl/timer_cntr_nb_pkg.sv
// Shared definitions for the timer/counter: terminal-count mode encodings.
package timer_cntr_nb_pkg;

    typedef enum logic [1:0] {
        MODE_FREE     = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_RELOAD   = 2'b10,
        MODE_PINGPONG = 2'b11
    } mode_e;

endpackage : timer_cntr_nb_pkg

// File: rtl/timer_cntr_nb_prescale.sv
// Prescaler: emits a count tick once every psc+1 enabled cycles.
module prescale_nb #(
    parameter int pw = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    input  logic          restart,
    input  logic [pw-1:0] psc,
    output logic          tick
);

    localparam logic [pw-1:0] PSC_ZERO = {pw{1'b0}};
    localparam logic [pw-1:0] PSC_ONE  = {{(pw-1){1'b0}}, 1'b1};

    logic [pw-1:0] r_psc_cnt;
    logic          w_hit;

    // >= rather than == so lowering psc below the running count ticks at once
    assign w_hit = (r_psc_cnt >= psc);
    assign tick  = en & ~restart & w_hit;

    // Prescale counter register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_psc_cnt <= PSC_ZERO;
        end else if (restart) begin
            r_psc_cnt <= PSC_ZERO;
        end else if (en) begin
            if (w_hit) begin
                r_psc_cnt <= PSC_ZERO;
            end else begin
                r_psc_cnt <= r_psc_cnt + PSC_ONE;
            end
        end else begin
            r_psc_cnt <= r_psc_cnt;
        end
    end

endmodule : prescale_nb

// File: rtl/timer_cntr_nb.sv
// Up/down timer/counter with prescaler, modulo limit, four terminal-count
// modes, compare match and a registered one-cycle terminal pulse.
module timer_cntr_nb
    import timer_cntr_nb_pkg::*;
#(
    parameter int n  = 16,
    parameter int pw = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          en,
    input  logic          sclr,
    input  logic          ld,
    input  logic          up,
    input  logic [1:0]    mode,
    input  logic [n-1:0]  D,
    input  logic [n-1:0]  top,
    input  logic [n-1:0]  cmp,
    input  logic [pw-1:0] psc,
    output logic [n-1:0]  count,
    output logic          rco,
    output logic          cmp_match,
    output logic          done
);

    localparam logic [n-1:0] CNT_ZERO = {n{1'b0}};
    localparam logic [n-1:0] CNT_ONE  = {{(n-1){1'b0}}, 1'b1};

    logic [n-1:0] r_count;
    logic         r_dir;
    logic         r_done;
    logic         r_rco;

    logic [n-1:0] w_count_nxt;
    logic         w_dir_nxt;
    logic         w_done_nxt;
    logic         w_rco_nxt;
    logic         w_tick;
    logic         w_eff_up;
    logic         w_terminal;
    mode_e        w_mode;

    prescale_nb #(.pw(pw)) u_prescale (
        .clk     (clk),
        .clr_n   (clr_n),
        .en      (en),
        .restart (sclr | ld),
        .psc     (psc),
        .tick    (w_tick)
    );

    assign w_mode     = mode_e'(mode);
    assign w_eff_up   = (w_mode == MODE_PINGPONG) ? r_dir : up;
    assign w_terminal = w_eff_up ? (r_count >= top) : (r_count == CNT_ZERO);

    // Next-state logic: clear > load > tick > hold
    always_comb begin
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_done_nxt  = r_done;
        w_rco_nxt   = 1'b0;
        if (sclr) begin
            w_count_nxt = CNT_ZERO;
            w_done_nxt  = 1'b0;
            w_dir_nxt   = up;
        end else if (ld) begin
            w_count_nxt = D;
            w_done_nxt  = 1'b0;
            w_dir_nxt   = up;
        end else if (w_tick && !r_done) begin
            if (!w_terminal) begin
                w_count_nxt = w_eff_up ? (r_count + CNT_ONE) : (r_count - CNT_ONE);
            end else begin
                w_rco_nxt = 1'b1;
                case (w_mode)
                    MODE_FREE:     w_count_nxt = w_eff_up ? CNT_ZERO : top;
                    MODE_ONESHOT:  w_done_nxt  = 1'b1;
                    MODE_RELOAD:   w_count_nxt = D;
                    MODE_PINGPONG: begin
                        w_dir_nxt = ~r_dir;
                        // Turn around: step one value in the new direction
                        if (top == CNT_ZERO) begin
                            w_count_nxt = CNT_ZERO;
                        end else begin
                            w_count_nxt = r_dir ? (r_count - CNT_ONE) : (r_count + CNT_ONE);
                        end
                    end
                    default:       w_count_nxt = r_count;
                endcase
            end
        end else begin
            w_count_nxt = r_count;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_count <= CNT_ZERO;
            r_dir   <= 1'b1;
            r_done  <= 1'b0;
            r_rco   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_done  <= w_done_nxt;
            r_rco   <= w_rco_nxt;
        end
    end

    assign count     = r_count;
    assign rco       = r_rco;
    assign done      = r_done;
    assign cmp_match = (r_count == cmp);

endmodule : timer_cntr_nb

// File: tb/tb_timer_cntr_nb.sv
// Directed self-checking bench for timer_cntr_nb; inputs change and outputs
// are sampled on the falling clock edge.
module tb_timer_cntr_nb;

    logic        clk;
    logic        clr_n;
    logic        en;
    logic        sclr;
    logic        ld;
    logic        up;
    logic [1:0]  mode;
    logic [15:0] D;
    logic [15:0] top;
    logic [15:0] cmp;
    logic [7:0]  psc;
    logic [15:0] count;
    logic        rco;
    logic        cmp_match;
    logic        done;

    int n_cmp;
    int n_bad;
    int pp_exp [9];

    timer_cntr_nb #(.n(16), .pw(8)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .en        (en),
        .sclr      (sclr),
        .ld        (ld),
        .up        (up),
        .mode      (mode),
        .D         (D),
        .top       (top),
        .cmp       (cmp),
        .psc       (psc),
        .count     (count),
        .rco       (rco),
        .cmp_match (cmp_match),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        clr_n = 1'b0; en = 1'b0; sclr = 1'b0; ld = 1'b0; up = 1'b1;
        mode = 2'b00; D = 16'd0; top = 16'd0; cmp = 16'd0; psc = 8'd0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (count !== 16'd0 || rco !== 1'b0 || done !== 1'b0 || cmp_match !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: count=%0d rco=%b done=%b cmp_match=%b, want 0 0 0 1",
                     count, rco, done, cmp_match);
        end
        clr_n = 1'b1;
    endtask

    task automatic test_free_up();
        logic [15:0] exp_c;
        mode = 2'b00; up = 1'b1; top = 16'd4; psc = 8'd0; cmp = 16'd3; en = 1'b1; sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        n_cmp++;
        if (count !== 16'd0 || rco !== 1'b0) begin
            n_bad++;
            $display("FAIL free_up_clear: count=%0d rco=%b, want 0 0", count, rco);
        end
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            exp_c = 16'(k % 5);
            n_cmp++;
            if (count !== exp_c || rco !== (exp_c == 16'd0) || cmp_match !== (exp_c == 16'd3)) begin
                n_bad++;
                $display("FAIL free_up k=%0d: count=%0d rco=%b cmp_match=%b, want %0d %b %b",
                         k, count, rco, cmp_match, exp_c, (exp_c == 16'd0), (exp_c == 16'd3));
            end
        end
    endtask

    task automatic test_free_down();
        logic [15:0] exp_c;
        logic        exp_r;
        mode = 2'b00; up = 1'b0; top = 16'd3; psc = 8'd2; cmp = 16'd9; sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            case ((k / 3) % 4)
                0:       exp_c = 16'd0;
                1:       exp_c = 16'd3;
                2:       exp_c = 16'd2;
                default: exp_c = 16'd1;
            endcase
            exp_r = (k % 3 == 0) && ((k / 3) % 4 == 1);
            n_cmp++;
            if (count !== exp_c || rco !== exp_r) begin
                n_bad++;
                $display("FAIL free_down k=%0d: count=%0d rco=%b, want %0d %b",
                         k, count, rco, exp_c, exp_r);
            end
        end
    endtask

    task automatic test_oneshot();
        logic [15:0] exp_c;
        mode = 2'b01; up = 1'b1; top = 16'd5; D = 16'd2; psc = 8'd0; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        n_cmp++;
        if (count !== 16'd2 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_load: count=%0d done=%b, want 2 0", count, done);
        end
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            exp_c = (k < 3) ? 16'(2 + k) : 16'd5;
            n_cmp++;
            if (count !== exp_c || done !== (k >= 4) || rco !== (k == 4)) begin
                n_bad++;
                $display("FAIL oneshot k=%0d: count=%0d done=%b rco=%b, want %0d %b %b",
                         k, count, done, rco, exp_c, (k >= 4), (k == 4));
            end
        end
        sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        n_cmp++;
        if (count !== 16'd0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL oneshot_sclr: count=%0d done=%b, want 0 0", count, done);
        end
    endtask

    task automatic test_reload();
        logic [15:0] exp_c;
        mode = 2'b10; up = 1'b0; D = 16'd7; top = 16'd3; psc = 8'd0; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_c = (k <= 7) ? 16'(7 - k) : 16'(15 - k);
            n_cmp++;
            if (count !== exp_c || rco !== (k == 8)) begin
                n_bad++;
                $display("FAIL reload k=%0d: count=%0d rco=%b, want %0d %b",
                         k, count, rco, exp_c, (k == 8));
            end
        end
        ld = 1'b1; sclr = 1'b1;
        @(negedge clk);
        ld = 1'b0; sclr = 1'b0;
        n_cmp++;
        if (count !== 16'd0 || rco !== 1'b0) begin
            n_bad++;
            $display("FAIL sclr_over_ld: count=%0d rco=%b, want 0 0", count, rco);
        end
    endtask

    task automatic test_pingpong();
        logic [15:0] exp_c;
        pp_exp = '{0, 1, 2, 3, 2, 1, 0, 1, 2};
        mode = 2'b11; up = 1'b1; top = 16'd3; cmp = 16'd2; psc = 8'd0; sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            exp_c = 16'(pp_exp[k]);
            n_cmp++;
            if (count !== exp_c || rco !== (k == 4 || k == 7) || cmp_match !== (exp_c == 16'd2)) begin
                n_bad++;
                $display("FAIL pingpong k=%0d: count=%0d rco=%b cmp_match=%b, want %0d %b %b",
                         k, count, rco, cmp_match, exp_c, (k == 4 || k == 7), (exp_c == 16'd2));
            end
        end
    endtask

    task automatic test_enable_hold();
        mode = 2'b00; up = 1'b1; top = 16'd20; psc = 8'd0; cmp = 16'd9; sclr = 1'b1;
        @(negedge clk);
        sclr = 1'b0;
        repeat (2) @(negedge clk);
        en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (count !== 16'd2) begin
            n_bad++;
            $display("FAIL enable_hold: count=%0d, want 2", count);
        end
        en = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (count !== 16'd3) begin
            n_bad++;
            $display("FAIL enable_resume: count=%0d, want 3", count);
        end
    endtask

    task automatic test_async_clr();
        mode = 2'b01; up = 1'b1; top = 16'd9; D = 16'd5; psc = 8'd0; cmp = 16'd0; ld = 1'b1;
        @(negedge clk);
        ld = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (count !== 16'd9 || done !== 1'b1 || rco !== 1'b1) begin
            n_bad++;
            $display("FAIL async_pre: count=%0d done=%b rco=%b, want 9 1 1", count, done, rco);
        end
        #2 clr_n = 1'b0;
        #1;
        n_cmp++;
        if (count !== 16'd0 || done !== 1'b0 || rco !== 1'b0 || cmp_match !== 1'b1) begin
            n_bad++;
            $display("FAIL async_clr: count=%0d done=%b rco=%b cmp_match=%b, want 0 0 0 1",
                     count, done, rco, cmp_match);
        end
        @(negedge clk);
        clr_n = 1'b1; mode = 2'b00; top = 16'd20;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            n_cmp++;
            if (count !== 16'(k)) begin
                n_bad++;
                $display("FAIL async_resume k=%0d: count=%0d, want %0d", k, count, k);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_free_up();
        test_free_down();
        test_oneshot();
        test_reload();
        test_pingpong();
        test_enable_hold();
        test_async_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_timer_cntr_nb

// File: doc/timer_cntr_nb.md
# timer_cntr_nb

Parametrised timer/counter: n-bit up/down counter with a programmable prescaler, modulo limit (`top`), four terminal-count modes (free-run wrap, one-shot, auto-reload, ping-pong), compare-match output and a direction-aware single-cycle `rco` pulse. It is the general counting resource for the SolarRAT peripheral set: interval timers, PWM bases, and event counters driven from CPU-written configuration registers.

## Interface
- `n`, 16, counter width
- `pw`, 8, prescaler width
- `clk`  in  1  rising-edge clock
- `clr_n`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable; low freezes counter and prescaler
- `sclr`  in  1  synchronous clear
- `ld`  in  1  synchronous load of `D`
- `up`  in  1  direction: 1 up, 0 down; ping-pong mode samples it only on `ld`/`sclr`
- `mode`  in  2  00 FREE, 01 ONESHOT, 10 RELOAD, 11 PINGPONG
- `D`  in  n  load / reload value
- `top`  in  n  modulo limit (upper terminal)
- `cmp`  in  n  compare value
- `psc`  in  pw  prescale divisor minus one
- `count`  out  n  current count
- `rco`  out  1  registered one-cycle terminal pulse
- `cmp_match`  out  1  `count == cmp`, combinational from registered `count`
- `done`  out  1  one-shot expired, counter halted

## Operation
- Priority: `clr_n` low > `sclr` > `ld` > (`en` && tick) > hold.
- Reset (`clr_n`=0): `count`=0, prescaler=0, `rco`=0, `done`=0, internal `dir`=1 (up); `cmp_match` follows `count`, so it reads 1 if `cmp`=0.
- `sclr`: `count`=0, prescaler=0, `done`=0, `dir`=`up`.
- `ld`: `count`=`D`, prescaler=0, `done`=0, `dir`=`up`.
- Prescaler: with `en`=1, increments each cycle. Tick occurs when `psc_cnt >= psc`; on a tick `psc_cnt` returns to 0. `psc`=0 gives a tick on every enabled cycle. Lowering `psc` below `psc_cnt` forces a tick on the next enabled cycle.
- Effective direction: `dir` in PINGPONG, otherwise `up`.
- Terminal condition: counting up, `count >= top`; counting down, `count == 0`.
- Tick when not terminal: `count` ±1, mod 2^n.
- Tick at terminal, by mode:
  - FREE: up → 0; down → `top`.
  - ONESHOT: `count` holds; `done`=1. Further ticks are ignored until `ld` or `sclr`.
  - RELOAD: `count`=`D`.
  - PINGPONG: `dir` inverts and `count` steps one value in the new direction. If `top`=0, `count` stays 0.
- `rco` is 1 for exactly the cycle after each terminal tick. In ONESHOT it pulses once, not again while `done`=1.
- `top`=0 in FREE (either direction): `count` stays 0 and `rco` pulses on every tick.
- A mode change takes effect on the next tick and does not clear `done`.

## Timing
- `count` updates on the clock edge of the tick cycle, so a new value is visible one cycle later.
- Prescaled period: `psc+1` enabled cycles per step.
- FREE up period: `(top+1)·(psc+1)` cycles. PINGPONG full period: `2·top·(psc+1)` cycles.
- `rco` latency: one cycle after the terminal tick edge, coincident with the wrapped/reloaded `count`.
- `cmp_match`: zero latency relative to `count`.
- `clr_n` deassertion is synchronized by the system reset tree; the block itself does not resynchronize it.

## Structure
- Shared package/include: mode constants `MODE_FREE`, `MODE_ONESHOT`, `MODE_RELOAD`, `MODE_PINGPONG`.
- Sub-module `prescale_nb #(pw)`: ports `clk`, `clr_n`, `en`, `restart`, `psc`, `tick`. Instantiated once.
- Top level holds `count`, `dir`, `done`, the `rco` register and the terminal/next-state logic.

## Test plan
- FREE up, `top`=4, `psc`=0, `en`=1 after reset → `count` 0,1,2,3,4,0…; `rco` high only in the cycle `count` returns to 0; period 5.
- FREE down, `top`=3, `psc`=2 → `count` 0→3→2→1→0, each value held 3 cycles; `rco` high for one cycle with each 0→3 wrap.
- ONESHOT up, `ld` with `D`=2, `top`=5 → `count` stops at 5; `done`=1; single `rco` pulse; extra ticks cause no change; `sclr` → `count`=0, `done`=0.
- RELOAD down, `D`=7 → 7…0 then 7, with `rco` at each reload. Then `ld` and `sclr` in the same cycle → `sclr` wins, `count`=0.
- PINGPONG, `top`=3 → 0,1,2,3,2,1,0,1…; `rco` after each turn at 3 and at 0; `cmp`=2 gives `cmp_match` pulses at both crossings.
- `clr_n` pulsed low mid-count with `count`=9 → all outputs take reset values immediately, without waiting for a clock edge; counting resumes from 0 after release.
